// File: rtl/acu_pwl_eval.sv
// acu_pwl_eval: 64-lane piecewise-linear evaluator, y = sat8(((x*slope) >>> SHIFT) + offset).
// LANES_PER_CYCLE multipliers are time-multiplexed over the captured vector in a
// two-stage pipeline (multiply, then shift/add/clamp). The full result vector is
// presented under a valid/ready handshake.
// Build option: define ACU_PWL_EVAL_SAT_EN to clamp results to [-128, 127];
// without it the sum is wrapped to its low 8 bits.
module acu_pwl_eval #(
  parameter int LANES_PER_CYCLE = 8,
  parameter int SHIFT           = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_x,
  input  logic [511:0] in_slope,
  input  logic [511:0] in_offset,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] out_data,
  output logic         busy
);

  localparam int P  = LANES_PER_CYCLE;
  localparam int N  = 64 / P;
  localparam int BW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t              state_reg, state_next;
  logic [BW-1:0]       beat_reg;
  logic [511:0]        x_reg, slope_reg, offset_reg;
  logic [511:0]        out_data_reg;
  logic                out_valid_reg;

  // Stage-1 pipeline registers: products and matching offsets for one beat
  logic                s1_valid_reg;
  logic [BW-1:0]       s1_beat_reg;
  logic signed [16:0]  prod_reg  [P];
  logic signed [7:0]   offs_reg  [P];
  logic signed [16:0]  prod_next [P];
  logic signed [7:0]   offs_next [P];
  logic [7:0]          res       [P];

  // Next-state decode; the last beat leaves RUN, DRAIN flushes stage 2
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = RUN;
      RUN:     if (beat_reg == BW'(N - 1)) state_next = DRAIN;
      DRAIN:   state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  generate
    for (genvar gi = 0; gi < P; gi++) begin : g_lane
      int                 lane;
      logic signed [7:0]  x_l;
      logic signed [8:0]  s_l;
      logic signed [17:0] p_ext;
      logic signed [17:0] off_ext;
      logic signed [17:0] s_sum;

      // Lane served by multiplier gi in the current beat
      assign lane          = (N > 1) ? int'(beat_reg) * P + gi : gi;
      assign x_l           = x_reg[lane*8 +: 8];
      assign s_l           = {1'b0, slope_reg[lane*8 +: 8]};
      assign prod_next[gi] = x_l * s_l;
      assign offs_next[gi] = offset_reg[lane*8 +: 8];

      // Stage 2 arithmetic at 18 bits so neither the shift nor the add can overflow
      assign p_ext   = {prod_reg[gi][16], prod_reg[gi]};
      assign off_ext = {{10{offs_reg[gi][7]}}, offs_reg[gi]};
      assign s_sum   = (p_ext >>> SHIFT) + off_ext;

      // Reduce the 18-bit sum to the 8-bit lane result
      always_comb begin
        res[gi] = s_sum[7:0];
`ifdef ACU_PWL_EVAL_SAT_EN
        if (s_sum > 18'sd127)       res[gi] = 8'h7F;
        else if (s_sum < -18'sd128) res[gi] = 8'h80;
`endif
      end
    end
  endgenerate

  // Capture, beat sequencing, both pipeline stages and the output register
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_reg      <= '0;
      x_reg         <= '0;
      slope_reg     <= '0;
      offset_reg    <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      s1_valid_reg  <= 1'b0;
      s1_beat_reg   <= '0;
      for (int j = 0; j < P; j++) begin
        prod_reg[j] <= '0;
        offs_reg[j] <= '0;
      end
    end else begin
      if (state_reg == IDLE && in_valid) begin
        x_reg      <= in_x;
        slope_reg  <= in_slope;
        offset_reg <= in_offset;
        beat_reg   <= '0;
      end else if (state_reg == RUN) begin
        beat_reg <= beat_reg + 1'b1;
      end
      s1_valid_reg <= (state_reg == RUN);
      s1_beat_reg  <= beat_reg;
      if (state_reg == RUN) begin
        for (int j = 0; j < P; j++) begin
          prod_reg[j] <= prod_next[j];
          offs_reg[j] <= offs_next[j];
        end
      end
      // Each output lane is written only by the beat that owns it
      for (int i = 0; i < 64; i++) begin
        if (s1_valid_reg && (int'(s1_beat_reg) == i / P))
          out_data_reg[i*8 +: 8] <= res[i % P];
      end
      out_valid_reg <= (state_next == DONE);
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign busy      = (state_reg == RUN) || (state_reg == DRAIN);
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;

endmodule

// File: tb/tb_acu_pwl_eval.sv
// tb_acu_pwl_eval: directed and random vectors through an 8-lane and a 1-lane
// evaluator, compared against an arithmetic reference of the activation formula.
module tb_acu_pwl_eval;

  localparam int SHIFT = 6;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [511:0] in_x, in_slope, in_offset, out_data;
  logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [511:0] b_in_x, b_in_slope, b_in_offset, b_out_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  acu_pwl_eval #(.LANES_PER_CYCLE(8), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_slope(in_slope), .in_offset(in_offset),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  acu_pwl_eval #(.LANES_PER_CYCLE(1), .SHIFT(SHIFT)) dut1 (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_x(b_in_x), .in_slope(b_in_slope), .in_offset(b_in_offset),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // Reference: y = clamp_or_wrap(floor(x*slope / 2^SHIFT) + offset) per lane
  function automatic logic [511:0] model(input logic [511:0] x, input logic [511:0] s,
                                         input logic [511:0] o);
    logic [511:0] r;
    for (int i = 0; i < 64; i++) begin
      int xv, sv, ov, v;
      xv = $signed(x[i*8 +: 8]);
      sv = int'(s[i*8 +: 8]);
      ov = $signed(o[i*8 +: 8]);
      v  = ((xv * sv) >>> SHIFT) + ov;
`ifdef ACU_PWL_EVAL_SAT_EN
      if (v > 127) v = 127;
      else if (v < -128) v = -128;
`endif
      r[i*8 +: 8] = v[7:0];
    end
    return r;
  endfunction

  // One vector through the 8-lane DUT; hold cycles of out_ready=0 in DONE
  task automatic run8(input string tag, input logic [511:0] x, input logic [511:0] s,
                      input logic [511:0] o, input logic [511:0] exp, input int hold);
    int edges;
    @(negedge clk);
    in_x = x; in_slope = s; in_offset = o; in_valid = 1'b1;
    chk({tag, ":in_ready_idle"}, 512'(in_ready), 512'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_x = rnd512(); in_slope = rnd512(); in_offset = rnd512();
    chk({tag, ":busy_run"}, 512'(busy), 512'(1));
    chk({tag, ":in_ready_run"}, 512'(in_ready), 512'(0));
    edges = 0;
    while (out_valid !== 1'b1 && edges < 200) begin
      @(posedge clk); #1;
      edges++;
    end
    chk({tag, ":latency"}, 512'(edges), 512'(9));
    chk({tag, ":data"}, out_data, exp);
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_x = rnd512(); in_slope = rnd512(); in_offset = rnd512();
      @(posedge clk); #1;
      chk({tag, ":hold_valid"}, 512'(out_valid), 512'(1));
      chk({tag, ":hold_data"}, out_data, exp);
      chk({tag, ":hold_in_ready"}, 512'(in_ready), 512'(0));
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, ":valid_drop"}, 512'(out_valid), 512'(0));
    chk({tag, ":back_idle"}, 512'(in_ready), 512'(1));
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [511:0] ramp, rx, rs, ro, e;
    int edges;

    for (int i = 0; i < 64; i++) ramp[i*8 +: 8] = 8'(i);

    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; in_x = '0; in_slope = '0; in_offset = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_x = '0; b_in_slope = '0; b_in_offset = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 512'(in_ready), 512'(1));
    chk("rst_out_valid", 512'(out_valid), 512'(0));
    chk("rst_busy", 512'(busy), 512'(0));
    chk("rst_out_data", out_data, '0);
    chk("rst1_in_ready", 512'(b_in_ready), 512'(1));
    chk("rst1_busy", 512'(b_busy), 512'(0));
    rst = 1'b0;

    run8("basic", {64{8'h10}}, {64{8'h3E}}, {64{8'h80}}, {64{8'h8F}}, 0);
`ifdef ACU_PWL_EVAL_SAT_EN
    run8("pos_big", {64{8'h7F}}, {64{8'hFF}}, {64{8'h60}}, {64{8'h7F}}, 0);
    run8("neg_big", {64{8'h80}}, {64{8'hFF}}, {64{8'h80}}, {64{8'h80}}, 5);
`else
    run8("pos_big", {64{8'h7F}}, {64{8'hFF}}, {64{8'h60}}, {64{8'h5A}}, 0);
    run8("neg_big", {64{8'h80}}, {64{8'hFF}}, {64{8'h80}}, {64{8'h82}}, 5);
`endif
    run8("ramp", ramp, {64{8'h40}}, '0, ramp, 0);

    // Reset while beat 3 is being issued
    @(negedge clk);
    in_x = rnd512(); in_slope = rnd512(); in_offset = rnd512(); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_out_valid", 512'(out_valid), 512'(0));
    chk("midrst_busy", 512'(busy), 512'(0));
    chk("midrst_in_ready", 512'(in_ready), 512'(1));
    chk("midrst_out_data", out_data, '0);
    rx = rnd512(); rs = rnd512(); ro = rnd512();
    run8("after_rst", rx, rs, ro, model(rx, rs, ro), 0);

    for (int v = 0; v < 5; v++) begin
      rx = rnd512(); rs = rnd512(); ro = rnd512();
      run8($sformatf("rand%0d", v), rx, rs, ro, model(rx, rs, ro), int'($urandom_range(0, 2)));
    end

    // Single-multiplier instance: ordering across 64 beats, then one random vector
    for (int v = 0; v < 2; v++) begin
      if (v == 0) begin
        rx = ramp; rs = {64{8'h40}}; ro = '0; e = ramp;
      end else begin
        rx = rnd512(); rs = rnd512(); ro = rnd512(); e = model(rx, rs, ro);
      end
      @(negedge clk);
      b_in_x = rx; b_in_slope = rs; b_in_offset = ro; b_in_valid = 1'b1;
      @(posedge clk); #1;
      b_in_valid = 1'b0;
      b_in_x = rnd512();
      edges = 0;
      while (b_out_valid !== 1'b1 && edges < 200) begin
        @(posedge clk); #1;
        edges++;
      end
      chk($sformatf("p1_latency%0d", v), 512'(edges), 512'(65));
      chk($sformatf("p1_data%0d", v), b_out_data, e);
      @(negedge clk);
      b_out_ready = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("p1_back_idle%0d", v), 512'(b_in_ready), 512'(1));
      @(negedge clk);
      b_out_ready = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
